// File: rtl/alu_slice_serial_if.sv
// alu_slice_serial_if: start/done request and result bus between microsequencer and serial ALU
interface alu_slice_serial_if #(parameter int WIDTH = 16);
    logic             start;
    logic [3:0]       s;
    logic             m;
    logic             cin_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f;
    logic             cout_n;
    logic             aeb;
    logic             zero;
    logic             ovf;
    modport master(output start, s, m, cin_n, a, b, input busy, done, f, cout_n, aeb, zero, ovf);
    modport slave(input start, s, m, cin_n, a, b, output busy, done, f, cout_n, aeb, zero, ovf);
endinterface

// File: rtl/alu_slice_serial.sv
// alu_slice_serial: 74181-compatible ALU evaluating one 4-bit slice per clock, carry rippled through a register
module alu_slice_serial #(parameter int WIDTH = 16) (
    input logic clk,
    input logic reset,
    alu_slice_serial_if.slave bus
);
    localparam int NS = WIDTH / 4;
    localparam int IW = NS > 1 ? $clog2(NS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_r, b_r;
    logic [3:0]       s_r;
    logic             m_r, cr, c3_r;
    logic [IW+1:0]    sh;
    logic [3:0]       as, bs, e, d, g, p, fs;
    logic             c0, c1, c2, c3, c4;
    assign sh = {idx, 2'b00};
    assign as = 4'(a_r >> sh);
    assign bs = 4'(b_r >> sh);
    assign e  = ~(as & bs & {4{s_r[3]}} | as & ~bs & {4{s_r[2]}});
    assign d  = ~(~bs & {4{s_r[1]}} | bs & {4{s_r[0]}} | as);
    // active-high generate/propagate; carries below are active-high, the register holds Cn active-low
    assign g  = ~e;
    assign p  = ~d;
    assign c0 = ~cr;
    assign c1 = g[0] | p[0] & c0;
    assign c2 = g[1] | p[1] & g[0] | p[1] & p[0] & c0;
    assign c3 = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & c0;
    assign c4 = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0] | (&p) & c0;
    assign fs = e ^ d ^ ({c3, c2, c1, c0} | {4{m_r}});
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            a_r        <= '0;
            b_r        <= '0;
            s_r        <= '0;
            m_r        <= 1'b0;
            cr         <= 1'b1;
            c3_r       <= 1'b0;
            bus.f      <= '0;
            bus.cout_n <= 1'b1;
            bus.aeb    <= 1'b0;
            bus.zero   <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    a_r      <= bus.a;
                    b_r      <= bus.b;
                    s_r      <= bus.s;
                    m_r      <= bus.m;
                    cr       <= bus.cin_n;
                    idx      <= '0;
                    bus.f    <= '0;
                    bus.busy <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    bus.f <= (bus.f & ~(WIDTH'(4'hf) << sh)) | (WIDTH'(fs) << sh);
                    cr    <= ~c4;
                    c3_r  <= c3;
                    idx   <= idx + 1'b1;
                    state <= idx == IW'(NS - 1) ? DONE : RUN;
                end
                DONE: begin
                    bus.aeb    <= &bus.f;
                    bus.zero   <= ~|bus.f;
                    bus.cout_n <= cr;
                    bus.ovf    <= ~m_r & (c3_r ^ ~cr);
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_slice_serial.sv
// tb_alu_slice_serial: scoreboard bench comparing the serial ALU against a 74181 function-table model
module tb_alu_slice_serial;
    localparam int WIDTH = 16;
    localparam int NS = WIDTH / 4;
    typedef struct packed {
        logic [WIDTH-1:0] f;
        logic             cout_n;
        logic             aeb;
        logic             zero;
        logic             ovf;
        logic [31:0]      cyc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic prev_done = 1'b0;
    exp_t q[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    alu_slice_serial_if #(.WIDTH(WIDTH)) bus();
    alu_slice_serial #(.WIDTH(WIDTH)) dut(.clk(clk), .reset(reset), .bus(bus));
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask
    function automatic exp_t mk(input logic [WIDTH-1:0] f, input logic c, input logic e, input logic z, input logic o);
        exp_t r;
        r = '0;
        r.f = f; r.cout_n = c; r.aeb = e; r.zero = z; r.ovf = o;
        return r;
    endfunction
    // arithmetic column of the 74181 table as two addends plus carry; logic column directly
    function automatic exp_t model(input logic [3:0] s, input logic m, input logic cin_n, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x, y, lg, half, lo, ones;
        logic [WIDTH:0] sum;
        logic cin;
        ones = '1;
        half = ones >> 1;
        cin = ~cin_n;
        case (s)
            4'h0: begin x = a;       y = '0;      lg = ~a;       end
            4'h1: begin x = a | b;   y = '0;      lg = ~(a | b); end
            4'h2: begin x = a | ~b;  y = '0;      lg = ~a & b;   end
            4'h3: begin x = ones;    y = '0;      lg = '0;       end
            4'h4: begin x = a;       y = a & ~b;  lg = ~(a & b); end
            4'h5: begin x = a | b;   y = a & ~b;  lg = ~b;       end
            4'h6: begin x = a;       y = ~b;      lg = a ^ b;    end
            4'h7: begin x = ones;    y = a & ~b;  lg = a & ~b;   end
            4'h8: begin x = a;       y = a & b;   lg = ~a | b;   end
            4'h9: begin x = a;       y = b;       lg = ~(a ^ b); end
            4'hA: begin x = a | ~b;  y = a & b;   lg = b;        end
            4'hB: begin x = ones;    y = a & b;   lg = a & b;    end
            4'hC: begin x = a;       y = a;       lg = ones;     end
            4'hD: begin x = a | b;   y = a;       lg = a | ~b;   end
            4'hE: begin x = a | ~b;  y = a;       lg = a | b;    end
            default: begin x = ones; y = a;       lg = a;        end
        endcase
        sum = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cin);
        lo = (x & half) + (y & half) + WIDTH'(cin);
        model = mk(m ? lg : sum[WIDTH-1:0], ~sum[WIDTH], 1'b0, 1'b0, ~m & (lo[WIDTH-1] ^ sum[WIDTH]));
        model.aeb = &model.f;
        model.zero = model.f == '0;
    endfunction
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && bus.done) begin
            chk("done_width", prev_done, 0);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                e = q.pop_front();
                chk("f", bus.f, e.f);
                chk("cout_n", bus.cout_n, e.cout_n);
                chk("aeb", bus.aeb, e.aeb);
                chk("zero", bus.zero, e.zero);
                chk("ovf", bus.ovf, e.ovf);
                chk("latency", cyc, e.cyc);
            end
        end
        prev_done = bus.done;
    end
    task automatic check_reset_vals();
        chk("rst_f", bus.f, 0);
        chk("rst_cout_n", bus.cout_n, 1);
        chk("rst_aeb", bus.aeb, 0);
        chk("rst_zero", bus.zero, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
    endtask
    task automatic issue(input logic [3:0] s, input logic m, input logic cin_n, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input exp_t e, input bit push, input bit disturb, input bit do_reset);
        exp_t ex;
        int k;
        bus.s = s; bus.m = m; bus.cin_n = cin_n; bus.a = a; bus.b = b; bus.start = 1'b1;
        if (push) begin
            ex = e;
            ex.cyc = 32'(cyc + NS + 2);
            q.push_back(ex);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
        bus.s = 4'($urandom); bus.m = 1'($urandom); bus.cin_n = 1'($urandom);
        chk("busy", bus.busy, 1);
        if (disturb) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        if (do_reset) begin
            @(negedge clk);
            reset = 1'b1;
            #1;
            check_reset_vals();
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        k = 0;
        while (!bus.done && k < 4 * NS + 10) begin
            @(negedge clk);
            k++;
        end
        if (!bus.done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 expected=1");
        end
    endtask
    initial begin
        logic [WIDTH-1:0] ra, rb;
        bus.start = 1'b0; bus.s = '0; bus.m = 1'b0; bus.cin_n = 1'b1; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        @(negedge clk);
        issue(4'b1001, 0, 1, 16'h1234, 16'h0FED, mk(16'h2221, 1, 0, 0, 0), 1, 0, 0);
        issue(4'b0110, 0, 0, 16'h0005, 16'h0007, mk(16'hFFFE, 1, 0, 0, 0), 1, 0, 0);
        issue(4'b0110, 0, 0, 16'h0007, 16'h0005, mk(16'h0002, 0, 0, 0, 0), 1, 0, 0);
        issue(4'b0110, 0, 1, 16'hBEEF, 16'hBEEF, mk(16'hFFFF, 1, 1, 0, 0), 1, 0, 0);
        issue(4'b0110, 0, 1, 16'hBEEF, 16'hBEEE, mk(16'h0000, 0, 0, 1, 0), 1, 0, 0);
        issue(4'b0110, 1, 1, 16'hF0F0, 16'hFF00, mk(16'h0FF0, 1, 0, 0, 0), 1, 0, 0);
        issue(4'b1001, 0, 1, 16'h7FFF, 16'h0001, mk(16'h8000, 1, 0, 0, 1), 1, 0, 0);
        issue(4'b1001, 0, 1, 16'h1234, 16'h0FED, mk(16'h2221, 1, 0, 0, 0), 1, 1, 0);
        issue(4'b1100, 1, 1, 16'h8001, 16'h0000, mk(16'hFFFF, 0, 1, 0, 0), 1, 0, 0);
        issue(4'b1001, 0, 1, 16'h5555, 16'h3333, mk('0, 1, 0, 0, 0), 0, 0, 1);
        issue(4'b0011, 1, 1, 16'hABCD, 16'h1234, mk(16'h0000, 1, 0, 1, 0), 1, 0, 0);
        for (int s = 0; s < 16; s++)
            for (int m = 0; m < 2; m++)
                for (int c = 0; c < 2; c++)
                    for (int r = 0; r < 2; r++) begin
                        ra = WIDTH'($urandom);
                        rb = WIDTH'($urandom);
                        issue(4'(s), 1'(m), 1'(c), ra, rb, model(4'(s), 1'(m), 1'(c), ra, rb), 1, 0, 0);
                    end
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL pending_results actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
